// File: rtl/store_merge_ctrl.sv
// Sub-word store controller: a read-modify-write merges byte/half stores into a
// memory word; aligned word stores go straight to the write cycle.
module store_merge_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam logic [2:0] CNT_LAST = 3'(RD_LAT-1);
  localparam logic [DATA_W-1:0] BMASK = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] HMASK = DATA_W'(16'hFFFF);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
  state_t state, nxt;

  logic [OFF_W-1:0]  off_in, off_q;
  logic              bad, accept, half_q;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] data_q, mask, merged;
  logic [OFF_W+2:0]  shamt;

  assign off_in = req_addr[OFF_W-1:0];

  always_comb begin
    bad = 1'b0;
    case (req_size)
      2'b00:   bad = (off_in != '0);
      2'b01:   bad = off_in[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end

  // err is a pulse taken while still in IDLE; hold off acceptance during it
  assign req_ready = (state == IDLE) && !err;
  assign accept    = req_valid && req_ready;
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign done      = (state == WRITE);

  assign shamt  = {off_q, 3'b000};
  assign mask   = (half_q ? HMASK : BMASK) << shamt;
  assign merged = (mem_rdata & ~mask) | ((data_q << shamt) & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept && !bad) nxt = (req_size == 2'b00) ? WRITE : READ;
      READ:  nxt = WAIT;
      WAIT:  if (cnt == CNT_LAST) nxt = WRITE;
      WRITE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      off_q     <= '0;
      half_q    <= 1'b0;
      data_q    <= '0;
      cnt       <= '0;
    end else begin
      err <= accept && bad;
      if (accept && !bad) begin
        mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        off_q    <= off_in;
        half_q   <= (req_size == 2'b01);
        data_q   <= req_data;
        if (req_size == 2'b00) mem_wdata <= req_data;
      end
      if (state == READ)      cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 3'd1;
      // read data is only looked at in the last WAIT cycle
      if (state == WAIT && cnt == CNT_LAST) mem_wdata <= merged;
    end
  end
endmodule

// File: tb/tb_store_merge_ctrl.sv
// Directed bench: three configurations (32b/lat1, 32b/lat3, 64b/lat1) with
// hand-computed merge results and cycle-exact strobe timing.
module tb_store_merge_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // u0: DATA_W=32, RD_LAT=1
  logic        v0 = 0, rdy0, rd0, wr0, dn0, er0;
  logic [31:0] a0 = 0, d0 = 0, ma0, wd0, rv0 = 0, rdat0;
  logic [1:0]  s0 = 0;
  logic [3:0]  rp0 = 0;
  int          nwr0 = 0, nrd0 = 0;
  assign rdat0 = rp0[0] ? rv0 : 32'hFFFF_FFFF;
  always @(posedge clk) begin
    rp0 <= {rp0[2:0], rd0};
    if (wr0) nwr0 <= nwr0 + 1;
    if (rd0) nrd0 <= nrd0 + 1;
  end
  store_merge_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_addr(a0),
    .req_data(d0), .req_size(s0), .mem_addr(ma0), .mem_rd(rd0), .mem_rdata(rdat0),
    .mem_wr(wr0), .mem_wdata(wd0), .done(dn0), .err(er0));

  // u1: DATA_W=32, RD_LAT=3
  logic        v1 = 0, rdy1, rd1, wr1, dn1, er1;
  logic [31:0] a1 = 0, d1 = 0, ma1, wd1, rv1 = 0, rdat1;
  logic [1:0]  s1 = 0;
  logic [3:0]  rp1 = 0;
  assign rdat1 = rp1[2] ? rv1 : 32'hFFFF_FFFF;
  always @(posedge clk) rp1 <= {rp1[2:0], rd1};
  store_merge_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
    .req_data(d1), .req_size(s1), .mem_addr(ma1), .mem_rd(rd1), .mem_rdata(rdat1),
    .mem_wr(wr1), .mem_wdata(wd1), .done(dn1), .err(er1));

  // u2: DATA_W=64, RD_LAT=1
  logic        v2 = 0, rdy2, rd2, wr2, dn2, er2;
  logic [31:0] a2 = 0, ma2;
  logic [63:0] d2 = 0, wd2, rv2 = 0, rdat2;
  logic [1:0]  s2 = 0;
  logic [3:0]  rp2 = 0;
  assign rdat2 = rp2[0] ? rv2 : 64'hFFFF_FFFF_FFFF_FFFF;
  always @(posedge clk) rp2 <= {rp2[2:0], rd2};
  store_merge_ctrl #(.DATA_W(64), .ADDR_W(32), .RD_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_addr(a2),
    .req_data(d2), .req_size(s2), .mem_addr(ma2), .mem_rd(rd2), .mem_rdata(rdat2),
    .mem_wr(wr2), .mem_wdata(wd2), .done(dn2), .err(er2));

  task automatic check_err(input string tag, input logic [31:0] addr, input logic [1:0] size);
    int rd_before, wr_before;
    rd_before = nrd0; wr_before = nwr0;
    v0 = 1; a0 = addr; s0 = size; d0 = 32'h1234_5678;
    step(); v0 = 0;                                   // T+1
    chk({tag, "_err"}, er0, 1);
    chk({tag, "_rd"}, rd0, 0);
    chk({tag, "_wr"}, wr0, 0);
    step();                                           // T+2
    chk({tag, "_err_off"}, er0, 0);
    chk({tag, "_ready"}, rdy0, 1);
    step();
    chk({tag, "_no_rd"}, nrd0 - rd_before, 0);
    chk({tag, "_no_wr"}, nwr0 - wr_before, 0);
  endtask

  task automatic sub_u0(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] data, input logic [31:0] rdv, input logic [31:0] exp);
    rv0 = rdv;
    v0 = 1; a0 = addr; s0 = size; d0 = data;
    step();                                           // T+1
    chk({tag, "_rd_t1"}, rd0, 1);
    chk({tag, "_addr_t1"}, ma0, {addr[31:2], 2'b00});
    // junk while busy must be ignored
    v0 = 1; d0 = 32'hCAFE_F00D; a0 = 32'h0;
    step();                                           // T+2
    chk({tag, "_idle_t2"}, {rd0, wr0}, 2'b00);
    v0 = 0;
    step();                                           // T+3
    chk({tag, "_wr_t3"}, {wr0, dn0, rd0}, 3'b110);
    chk({tag, "_wdata"}, wd0, exp);
    chk({tag, "_addr_t3"}, ma0, {addr[31:2], 2'b00});
    step();                                           // T+4
    chk({tag, "_ready_t4"}, {rdy0, wr0}, 2'b10);
  endtask

  initial begin
    int wr_snap;
    #1;
    chk("rst_ready", rdy0, 1);
    chk("rst_outs", {rd0, wr0, dn0, er0}, 4'b0000);
    chk("rst_addr_wdata", {ma0, wd0}, 64'h0);
    step(); rst_n = 1;
    step(); step();
    chk("post_rst_outs", {rd0, wr0, dn0, er0, ma0, wd0}, 68'h0);

    // aligned word store
    v0 = 1; a0 = 32'h100; d0 = 32'hDEAD_BEEF; s0 = 2'b00;
    step(); v0 = 0;
    chk("word_wr_done", {wr0, dn0, rd0}, 3'b110);
    chk("word_addr", ma0, 32'h100);
    chk("word_wdata", wd0, 32'hDEAD_BEEF);
    step();
    chk("word_after", {rdy0, wr0, dn0}, 3'b100);
    chk("word_no_rd", nrd0, 0);

    sub_u0("byte103", 32'h103, 2'b10, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344);
    sub_u0("byte101", 32'h101, 2'b10, 32'hFFFF_FF5C, 32'h1122_3344, 32'h1122_5C44);
    sub_u0("half102", 32'h102, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344);
    sub_u0("half100", 32'h100, 2'b01, 32'h0000_A5A5, 32'h1122_3344, 32'h1122_A5A5);

    check_err("half201", 32'h201, 2'b01);
    check_err("rsv200", 32'h200, 2'b11);
    check_err("word102", 32'h102, 2'b00);

    // RD_LAT=3 half store: write at T+5
    rv1 = 32'h1122_3344;
    v1 = 1; a1 = 32'h202; d1 = 32'h0000_BEEF; s1 = 2'b01;
    step(); v1 = 0;
    chk("lat3_rd_t1", rd1, 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("lat3_wr_t%0d", k), wr1, (k == 5));
    end
    chk("lat3_wdata", wd1, 32'hBEEF_3344);
    chk("lat3_addr", ma1, 32'h200);

    // 64-bit byte store
    rv2 = 64'h0;
    v2 = 1; a2 = 32'h1005; d2 = 64'h5A; s2 = 2'b10;
    step(); v2 = 0;
    chk("w64_rd", rd2, 1);
    chk("w64_addr", ma2, 32'h1000);
    step(); step();
    chk("w64_wr", wr2, 1);
    chk("w64_wdata", wd2, 64'h0000_5A00_0000_0000);

    // reset during WAIT aborts the store
    rv0 = 32'h1122_3344;
    v0 = 1; a0 = 32'h103; d0 = 32'hAA; s0 = 2'b10;
    step(); v0 = 0;
    chk("abort_rd", rd0, 1);
    step();                                           // WAIT
    wr_snap = nwr0;
    rst_n = 0; #1;
    chk("abort_outs", {rd0, wr0, dn0, er0, ma0, wd0}, 68'h0);
    chk("abort_ready", rdy0, 1);
    step(); step(); rst_n = 1;
    repeat (4) step();
    chk("abort_no_wr", nwr0 - wr_snap, 0);
    chk("abort_idle", {rdy0, rd0, wr0, ma0, wd0}, {3'b100, 64'h0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
